// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response channels between the MEM stage and data memory
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency 64-bit data memory target; DMEM_STATS_EN adds access counters
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0]       stat_rd,
   output logic [31:0]       stat_wr,
   output logic [31:0]       stat_err
`endif
);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        lat_write;
   logic [63:0] lat_addr;
   logic [63:0] lat_wdata;
   logic [63:0] rdata_q;
   logic        err_q;
   logic [63:0] mem [DEPTH];

   logic            accept;
   logic            resp_enter;
   logic            acc_write;
   logic [63:0]     acc_addr;
   logic [63:0]     acc_wdata;
   logic            acc_err;
   logic [IDXW-1:0] acc_idx;
   logic            mem_we;

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   assign accept = bus.req_valid && bus.req_ready;

   // With LATENCY==1 the RESP-entry edge is the acceptance edge, so the live request is used instead of the latch.
   assign acc_write = (state == IDLE) ? bus.req_write : lat_write;
   assign acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
   assign acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
   assign acc_err   = (acc_addr[2:0] != 3'd0) || ((acc_addr >> 3) >= 64'(DEPTH));
   assign acc_idx   = acc_addr[3 +: IDXW];

   assign resp_enter = (state != RESP) && (state_nxt == RESP) && !rst;
   assign mem_we     = resp_enter && acc_write && !acc_err;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: accept in IDLE, count down in WAIT, hold RESP until the consumer takes it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt == 4'd0) state_nxt = RESP;
         RESP: if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, latency counter and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= 64'd0;
         lat_wdata <= 64'd0;
         rdata_q   <= 64'd0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            cnt       <= CNT_LOAD;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (resp_enter) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || acc_write) ? 64'd0 : mem[acc_idx];
         end else if (state == RESP && bus.resp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
         end
      end
   end

   // Memory array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[acc_idx] <= acc_wdata;
   end

`ifdef DMEM_STATS_EN
   // Saturating per-kind access counters, bumped when a response is formed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd  <= 32'd0;
         stat_wr  <= 32'd0;
         stat_err <= 32'd0;
      end else if (resp_enter) begin
         if (acc_err) begin
            if (stat_err != 32'hFFFF_FFFF) stat_err <= stat_err + 32'd1;
         end else if (acc_write) begin
            if (stat_wr != 32'hFFFF_FFFF) stat_wr <= stat_wr + 32'd1;
         end else begin
            if (stat_rd != 32'hFFFF_FFFF) stat_rd <= stat_rd + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 2 and LATENCY 1 instances)
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dmem_responder_if bus ();
   dmem_responder_if bus1 ();

`ifdef DMEM_STATS_EN
   logic [31:0] stat_rd, stat_wr, stat_err;
   logic [31:0] stat_rd1, stat_wr1, stat_err1;
`endif

   dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DMEM_STATS_EN
      ,
      .stat_rd  (stat_rd),
      .stat_wr  (stat_wr),
      .stat_err (stat_err)
`endif
   );

   dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
`ifdef DMEM_STATS_EN
      ,
      .stat_rd  (stat_rd1),
      .stat_wr  (stat_wr1),
      .stat_err (stat_err1)
`endif
   );

   typedef struct {
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        err;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   // Full transaction on the LATENCY=2 instance: accept, measure latency, compare, handshake.
   task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rd, input logic exp_err);
      int   n;
      exp_t e;
      @(negedge clk);
      drive_req(wr, addr, wdata);
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 64'(n < 20), 64'd1);
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n), 64'd2);
      e = sb.pop_front();
      chk("rdata", bus.resp_rdata, e.rdata);
      chk("err", 64'(bus.resp_err), 64'(e.err));
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("resp_clear", {bus.resp_valid, bus.resp_err, bus.resp_rdata[61:0]}, 64'd0);
   endtask

   vec_t vecs[13];
   vec_t seq1[4];

   initial begin
      int   n;
      int   cyc;
      int   last_cyc;
      int   issued;
      int   nresp;
      logic adv;
      exp_t e;

      vecs[0]  = '{1'b1, 64'h10,                  64'hDEADBEEF_CAFEF00D, 64'h0,                  1'b0};
      vecs[1]  = '{1'b0, 64'h10,                  64'h0,                 64'hDEADBEEF_CAFEF00D, 1'b0};
      vecs[2]  = '{1'b1, 64'h0,                   64'h11112222_33334444, 64'h0,                  1'b0};
      vecs[3]  = '{1'b0, 64'h0C,                  64'h0,                 64'h0,                  1'b1};
      vecs[4]  = '{1'b0, 64'h2000,                64'h0,                 64'h0,                  1'b1};
      vecs[5]  = '{1'b1, 64'h2000,                64'hFFFFFFFF_FFFFFFFF, 64'h0,                  1'b1};
      vecs[6]  = '{1'b1, 64'h4,                   64'hEEEEEEEE_EEEEEEEE, 64'h0,                  1'b1};
      vecs[7]  = '{1'b0, 64'h0,                   64'h0,                 64'h11112222_33334444, 1'b0};
      vecs[8]  = '{1'b1, 64'h1FF8,                64'hA5A5A5A5_5A5A5A5A, 64'h0,                  1'b0};
      vecs[9]  = '{1'b0, 64'h1FF8,                64'h0,                 64'hA5A5A5A5_5A5A5A5A, 1'b0};
      vecs[10] = '{1'b0, 64'h80000000_00000010,   64'h0,                 64'h0,                  1'b1};
      vecs[11] = '{1'b1, 64'h10,                  64'h01234567_89ABCDEF, 64'h0,                  1'b0};
      vecs[12] = '{1'b0, 64'h10,                  64'h0,                 64'h01234567_89ABCDEF, 1'b0};

      seq1[0] = '{1'b1, 64'h0, 64'hCAFE0000_00000001, 64'h0,                 1'b0};
      seq1[1] = '{1'b1, 64'h8, 64'hCAFE0000_00000002, 64'h0,                 1'b0};
      seq1[2] = '{1'b0, 64'h0, 64'h0,                 64'hCAFE0000_00000001, 1'b0};
      seq1[3] = '{1'b0, 64'h8, 64'h0,                 64'hCAFE0000_00000002, 1'b0};

      bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = 64'd0; bus.req_wdata  = 64'd0;
      bus.resp_ready = 1'b0;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 64'd0; bus1.req_wdata = 64'd0;
      bus1.resp_ready = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_rdata", bus.resp_rdata, 64'd0);
      chk("rst_err", 64'(bus.resp_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 64'(bus.req_ready), 64'd1);

      // Table-driven transactions
      for (int i = 0; i < 13; i++)
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);

      // Response held off for 5 cycles while a second request waits
      @(negedge clk);
      drive_req(1'b0, 64'h10, 64'h0);
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      e.rdata = 64'h01234567_89ABCDEF; e.err = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive_req(1'b0, 64'h0, 64'h0);
      n = 1;
      while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("hold_latency", 64'(n), 64'd2);
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", 64'(bus.resp_valid), 64'd1);
         chk("hold_rdata", bus.resp_rdata, e.rdata);
         chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
         @(negedge clk);
      end
      e.rdata = 64'h11112222_33334444; e.err = 1'b0;
      sb.push_back(e);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("hold_release", 64'(bus.resp_valid), 64'd0);
      chk("hold_second_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("second_latency", 64'(n), 64'd2);
      e = sb.pop_front();
      chk("second_rdata", bus.resp_rdata, e.rdata);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;

      // Reset while a store waits in WAIT
      do_txn(1'b1, 64'h18, 64'h55550000_0000AAAA, 64'h0, 1'b0);
      @(negedge clk);
      drive_req(1'b1, 64'h18, 64'h99999999_99999999);
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
      @(negedge clk);
      chk("midrst_req_ready2", 64'(bus.req_ready), 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
      end
      do_txn(1'b0, 64'h18, 64'h0, 64'h55550000_0000AAAA, 1'b0);

      // LATENCY=1 instance, back-to-back with resp_ready held high
      bus1.resp_ready = 1'b1;
      issued = 0; nresp = 0; last_cyc = -1; adv = 1'b0;
      bus1.req_valid = 1'b1;
      bus1.req_write = seq1[0].wr; bus1.req_addr = seq1[0].addr; bus1.req_wdata = seq1[0].wdata;
      for (cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
         @(negedge clk);
         if (adv) begin
            adv = 1'b0;
            issued++;
            if (issued < 4) begin
               bus1.req_write = seq1[issued].wr;
               bus1.req_addr  = seq1[issued].addr;
               bus1.req_wdata = seq1[issued].wdata;
            end else begin
               bus1.req_valid = 1'b0;
            end
         end
         if (bus1.resp_valid) begin
            e = sb.pop_front();
            chk("l1_rdata", bus1.resp_rdata, e.rdata);
            chk("l1_err", 64'(bus1.resp_err), 64'(e.err));
            if (last_cyc >= 0) chk("l1_interval", 64'(cyc - last_cyc), 64'd2);
            last_cyc = cyc;
            nresp++;
         end
         if (bus1.req_ready && bus1.req_valid) begin
            e.rdata = seq1[issued].rdata; e.err = seq1[issued].err;
            sb.push_back(e);
            adv = 1'b1;
         end
      end
      chk("l1_resp_count", 64'(nresp), 64'd4);
      bus1.resp_ready = 1'b0;

      // Access mix after a fresh reset (counter check when stats are built in)
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_txn(1'b1, 64'h20, 64'h20202020_20202020, 64'h0, 1'b0);
      do_txn(1'b1, 64'h28, 64'h28282828_28282828, 64'h0, 1'b0);
      do_txn(1'b0, 64'h20, 64'h0, 64'h20202020_20202020, 1'b0);
      do_txn(1'b0, 64'h28, 64'h0, 64'h28282828_28282828, 1'b0);
      do_txn(1'b0, 64'h10, 64'h0, 64'h01234567_89ABCDEF, 1'b0);
      do_txn(1'b1, 64'h24, 64'h77777777_77777777, 64'h0, 1'b1);
      do_txn(1'b0, 64'h20, 64'h0, 64'h20202020_20202020, 1'b0);
`ifdef DMEM_STATS_EN
      chk("stat_rd", 64'(stat_rd), 64'd4);
      chk("stat_wr", 64'(stat_wr), 64'd2);
      chk("stat_err", 64'(stat_err), 64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
